text_ram_grid: RTL and testbench
================================

# text_ram_grid

Writable, parametrised character-code grid for the on-screen text layer of the Memory Game. It replaces the fixed message ROM with a RAM that game logic can update at run time: single-cell writes, a full-screen clear sweep, and a 3-digit decimal number writer for the score. The registered read port feeds the font ROM.

## Interface
- COLS, 17: columns in use; x ≥ COLS is out of range.
- ROWS, 4: rows in use; y ≥ ROWS is out of range.
- X_W, 5: column index width.
- Y_W, 5: row index width.
- CODE_W, 7: character code width (ASCII).
- BLANK, 0: code written by clear and used for suppressed leading zeros.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- char_yx  in  Y_W+X_W  read address {y, x}.
- char_code  out  CODE_W  registered read data.
- wr_en  in  1  single-cell write strobe.
- wr_yx  in  Y_W+X_W  write address {y, x}.
- wr_code  in  CODE_W  write data.
- clr_req  in  1  start the clear sweep.
- num_req  in  1  start the number write.
- num_yx  in  Y_W+X_W  cell of the most significant digit.
- num_val  in  10  unsigned value to print.
- busy  out  1  high while a clear or number operation runs.

## Operation
- Storage is ROWS×COLS cells. Power-up contents are irrelevant, because reset forces a clear.
- Read port:
  - Always active, including while busy.
  - char_code <= mem[y][x] on each clk edge.
  - An out-of-range address reads BLANK.
  - Read-during-write to the same cell returns the old data.
- FSM states: IDLE, CLEAR, HUND, TENS, WRITE.
- Commands are sampled only in IDLE. Priority is clr_req > num_req > wr_en; lower-priority requests in the same cycle are dropped, not queued.
- While busy=1, all command inputs are ignored.
- wr_en in IDLE:
  - Writes wr_code to wr_yx on that edge.
  - An out-of-range address writes nothing.
  - The FSM stays in IDLE.
- CLEAR:
  - An internal {y, x} counter starts at {0, 0} and writes BLANK to one cell per cycle.
  - Order is x fastest, wrapping x = COLS−1 → 0 with y+1.
  - After cell {ROWS−1, COLS−1} the FSM returns to IDLE.
- Number accept:
  - num_val ≥ 1000 saturates to 999.
  - The value, num_yx, and hundreds/tens counters are captured.
  - The FSM then enters HUND.
- HUND: each cycle, if v ≥ 100 then v −= 100 and h += 1; otherwise go to TENS.
- TENS: the same with 10, incrementing t; otherwise go to WRITE. The remainder is u.
- WRITE writes 3 cells over 3 cycles, at x, x+1, x+2 on row y:
  - Hundreds digit: code 48+h, or BLANK if h = 0.
  - Tens digit: code 48+t, or BLANK if h = 0 and t = 0.
  - Units digit: always 48+u.
  - Any digit cell with x+k ≥ COLS (or y out of range) is skipped, but still takes its cycle.
- Arithmetic: v is 10-bit unsigned; h, t, u are 4-bit. Column addition x+k is computed at X_W+1 bits, so there is no wrap-around into column 0.

## Timing
- Reset values: busy = 1, char_code = BLANK, state = CLEAR with counter {0, 0}.
- rst asserted mid-operation aborts that operation and restarts the clear.
- Read latency is 1 cycle: address at edge n gives data valid after edge n+1.
- Clear:
  - busy rises on the edge that accepts clr_req.
  - busy is high for exactly ROWS×COLS cycles.
  - The cycle after busy falls is IDLE and accepts commands.
- Number:
  - busy is high for exactly h + t + 5 cycles: (h+1) HUND + (t+1) TENS + 3 WRITE.
  - The worst case (999) is 23 cycles.
- A single-cell write completes on the accepting edge; busy does not rise.

## Test plan
- Reset, then hold rst low:
  - busy is high for 68 cycles (17×4), then low.
  - Reading any in-range cell gives 0.
- Write 67 to {0, 1}, then read {0, 1}: char_code = 67 one cycle later. Reading {0, 20} gives 0.
- num_req with num_val = 45 at {2, 13}:
  - busy is high for 9 cycles.
  - Cells 13, 14, 15 of row 2 read 0, 52, 53.
- num_val = 1023 at {2, 13}: cells read 57, 57, 57; busy is high for 23 cycles.
- num_val = 7 at {1, 15}: cells 15 and 16 read 0 and 0, the units digit is dropped as out of range, and busy is high for 5 cycles.
- clr_req, num_req and wr_en asserted in the same IDLE cycle: only the clear runs (68 busy cycles). Then assert rst mid-number-write: busy stays high and the clear restarts.

Source files
------------

// File: rtl/text_ram_grid_if.sv
// Command/read bus for the text-layer character grid.
// The game logic holds the master side; the grid RAM is the slave.
interface text_ram_grid_if #(
    parameter int X_W    = 5,
    parameter int Y_W    = 5,
    parameter int CODE_W = 7
);
    logic [Y_W+X_W-1:0] char_yx;
    logic [CODE_W-1:0]  char_code;
    logic               wr_en;
    logic [Y_W+X_W-1:0] wr_yx;
    logic [CODE_W-1:0]  wr_code;
    logic               clr_req;
    logic               num_req;
    logic [Y_W+X_W-1:0] num_yx;
    logic [9:0]         num_val;
    logic               busy;

    modport master (
        output char_yx, wr_en, wr_yx, wr_code, clr_req, num_req, num_yx, num_val,
        input  char_code, busy
    );

    modport slave (
        input  char_yx, wr_en, wr_yx, wr_code, clr_req, num_req, num_yx, num_val,
        output char_code, busy
    );
endinterface

// File: rtl/text_ram_grid.sv
// Writable character-code grid for the text layer: single-cell writes, a full clear
// sweep and a 3-digit decimal writer, with a registered read port toward the font ROM.
//
// state   | meaning
// IDLE    | accept clr_req > num_req > wr_en
// CLEAR   | write BLANK to one cell per cycle, x fastest
// HUND    | subtract 100 per cycle, counting hundreds
// TENS    | subtract 10 per cycle, counting tens
// WRITE   | write hundreds, tens, units digit cells
module text_ram_grid #(
    parameter int COLS   = 17,
    parameter int ROWS   = 4,
    parameter int X_W    = 5,
    parameter int Y_W    = 5,
    parameter int CODE_W = 7,
    parameter int BLANK  = 0
) (
    input  logic           clk,
    input  logic           rst,
    text_ram_grid_if.slave bus
);
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CODE_W-1:0] BLANK_C = CODE_W'(BLANK);
    localparam logic [CODE_W-1:0] ZERO_C  = CODE_W'(48);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HUND, S_TENS, S_WRITE} state_t;

    state_t             state_q;
    logic               busy_q;
    logic [Y_W-1:0]     cy_q;
    logic [X_W-1:0]     cx_q;
    logic [Y_W-1:0]     ny_q;
    logic [X_W-1:0]     nx_q;
    logic [9:0]         v_q;
    logic [3:0]         h_q;
    logic [3:0]         t_q;
    logic [1:0]         dig_q;
    logic [CODE_W-1:0]  char_code_q;
    logic [CODE_W-1:0]  mem_q [DEPTH];

    logic               mem_we;
    logic [Y_W-1:0]     mem_wy;
    logic [X_W:0]       mem_wx;
    logic [CODE_W-1:0]  mem_wdata;

    logic [Y_W-1:0]     rd_y;
    logic [X_W-1:0]     rd_x;

    // Column is carried at X_W+1 bits so x+k never wraps back into a valid column.
    function automatic logic in_range(input logic [Y_W-1:0] y, input logic [X_W:0] x);
        return (int'(y) < ROWS) && (int'(x) < COLS);
    endfunction

    function automatic logic [AW-1:0] cell_idx(input logic [Y_W-1:0] y, input logic [X_W:0] x);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction

    assign rd_y = bus.char_yx[Y_W+X_W-1:X_W];
    assign rd_x = bus.char_yx[X_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            char_code_q <= BLANK_C;
        end else if (in_range(rd_y, {1'b0, rd_x})) begin
            char_code_q <= mem_q[cell_idx(rd_y, {1'b0, rd_x})];
        end else begin
            char_code_q <= BLANK_C;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wy    = cy_q;
        mem_wx    = {1'b0, cx_q};
        mem_wdata = BLANK_C;
        case (state_q)
            S_IDLE: begin
                mem_wy    = bus.wr_yx[Y_W+X_W-1:X_W];
                mem_wx    = {1'b0, bus.wr_yx[X_W-1:0]};
                mem_wdata = bus.wr_code;
                mem_we    = bus.wr_en && !bus.clr_req && !bus.num_req;
            end
            S_CLEAR: begin
                mem_we = 1'b1;
            end
            S_WRITE: begin
                mem_wy = ny_q;
                mem_wx = {1'b0, nx_q} + (X_W+1)'(dig_q);
                mem_we = 1'b1;
                case (dig_q)
                    2'd0:    mem_wdata = (h_q == 4'd0) ? BLANK_C : ZERO_C + CODE_W'(h_q);
                    2'd1:    mem_wdata = (h_q == 4'd0 && t_q == 4'd0) ? BLANK_C
                                                                      : ZERO_C + CODE_W'(t_q);
                    default: mem_wdata = ZERO_C + CODE_W'(v_q[3:0]);
                endcase
            end
            default: ;
        endcase
        if (rst || !in_range(mem_wy, mem_wx)) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cell_idx(mem_wy, mem_wx)] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            cy_q    <= '0;
            cx_q    <= '0;
            ny_q    <= '0;
            nx_q    <= '0;
            v_q     <= '0;
            h_q     <= '0;
            t_q     <= '0;
            dig_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        cy_q    <= '0;
                        cx_q    <= '0;
                    end else if (bus.num_req) begin
                        state_q <= S_HUND;
                        busy_q  <= 1'b1;
                        v_q     <= (bus.num_val >= 10'd1000) ? 10'd999 : bus.num_val;
                        ny_q    <= bus.num_yx[Y_W+X_W-1:X_W];
                        nx_q    <= bus.num_yx[X_W-1:0];
                        h_q     <= '0;
                        t_q     <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cx_q == X_W'(COLS - 1)) begin
                        cx_q <= '0;
                        if (cy_q == Y_W'(ROWS - 1)) begin
                            cy_q    <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
                S_HUND: begin
                    if (v_q >= 10'd100) begin
                        v_q <= v_q - 10'd100;
                        h_q <= h_q + 1'b1;
                    end else begin
                        state_q <= S_TENS;
                    end
                end
                S_TENS: begin
                    if (v_q >= 10'd10) begin
                        v_q <= v_q - 10'd10;
                        t_q <= t_q + 1'b1;
                    end else begin
                        state_q <= S_WRITE;
                        dig_q   <= '0;
                    end
                end
                S_WRITE: begin
                    if (dig_q == 2'd2) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        dig_q   <= '0;
                    end else begin
                        dig_q <= dig_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.char_code = char_code_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_text_ram_grid.sv
// Randomized self-checking bench for text_ram_grid against a cell-array model.
module tb_text_ram_grid;
    localparam int COLS = 17, ROWS = 4, X_W = 5, Y_W = 5, CODE_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_ram_grid_if #(.X_W(X_W), .Y_W(Y_W), .CODE_W(CODE_W)) bus ();

    text_ram_grid #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .CODE_W(CODE_W), .BLANK(0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int model [ROWS][COLS];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b0;
        bus.num_req = 1'b0;
        bus.wr_yx   = '0;
        bus.wr_code = '0;
        bus.num_yx  = '0;
        bus.num_val = '0;
    endtask

    function automatic int model_rd(input int y, input int x);
        if (y < ROWS && x < COLS) return model[y][x];
        return 0;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                model[y][x] = 0;
    endtask

    task automatic chk_cell(input string tag, input int y, input int x);
        bus.char_yx = {Y_W'(y), X_W'(x)};
        tick();
        check(tag, int'(bus.char_code), model_rd(y, x));
    endtask

    task automatic scan(input string tag);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                chk_cell(tag, y, x);
    endtask

    // Counts busy cycles; command inputs are hammered while busy to prove they are ignored.
    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) break;
            n++;
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.clr_req = 1'($urandom_range(0, 1));
            bus.num_req = 1'($urandom_range(0, 1));
            bus.wr_yx   = {Y_W'($urandom_range(0, 3)), X_W'($urandom_range(0, 16))};
            bus.wr_code = CODE_W'($urandom_range(1, 127));
            bus.num_yx  = {Y_W'($urandom_range(0, 3)), X_W'($urandom_range(0, 16))};
            bus.num_val = 10'($urandom_range(0, 1023));
            tick();
        end
        idle_inputs();
        if (bus.busy) check("busy_timeout", 1, 0);
    endtask

    task automatic do_wr(input int y, input int x, input int code);
        bus.wr_en   = 1'b1;
        bus.wr_yx   = {Y_W'(y), X_W'(x)};
        bus.wr_code = CODE_W'(code);
        tick();
        idle_inputs();
        check("wr_no_busy", int'(bus.busy), 0);
        if (y < ROWS && x < COLS) model[y][x] = code;
    endtask

    task automatic do_num(input string tag, input int y, input int x, input int val);
        int v, h, t, u, n;
        int c [3];
        bus.num_req = 1'b1;
        bus.num_yx  = {Y_W'(y), X_W'(x)};
        bus.num_val = 10'(val);
        tick();
        idle_inputs();
        wait_busy(n);
        v = (val > 999) ? 999 : val;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        check(tag, n, h + t + 5);
        c[0] = (h == 0) ? 0 : 48 + h;
        c[1] = (h == 0 && t == 0) ? 0 : 48 + t;
        c[2] = 48 + u;
        for (int k = 0; k < 3; k++)
            if (y < ROWS && x + k < COLS) model[y][x + k] = c[k];
    endtask

    task automatic do_clr(input string tag, input bit extras);
        int n;
        bus.clr_req = 1'b1;
        if (extras) begin
            bus.num_req = 1'b1;
            bus.num_yx  = {Y_W'(0), X_W'(0)};
            bus.num_val = 10'd123;
            bus.wr_en   = 1'b1;
            bus.wr_yx   = {Y_W'(1), X_W'(1)};
            bus.wr_code = 7'd99;
        end
        tick();
        idle_inputs();
        wait_busy(n);
        check(tag, n, ROWS * COLS);
        model_clear();
    endtask

    initial begin
        int n;
        idle_inputs();
        bus.char_yx = '0;
        model_clear();

        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", int'(bus.busy), 1);
        check("rst_code", int'(bus.char_code), 0);
        rst = 1'b0;
        wait_busy(n);
        check("rst_clear_len", n, 68);
        scan("rst_scan");

        // Read-during-write to the same cell returns the old data.
        bus.char_yx = {Y_W'(0), X_W'(1)};
        bus.wr_en   = 1'b1;
        bus.wr_yx   = {Y_W'(0), X_W'(1)};
        bus.wr_code = 7'd67;
        tick();
        idle_inputs();
        check("rdw_old", int'(bus.char_code), 0);
        model[0][1] = 67;
        chk_cell("wr_67", 0, 1);
        chk_cell("rd_oor_x20", 0, 20);
        do_wr(5, 3, 88);
        do_wr(0, 17, 88);
        chk_cell("wr_oor_y_noeffect", 1, 3);

        do_num("num45_busy", 2, 13, 45);
        chk_cell("num45_h", 2, 13);
        chk_cell("num45_t", 2, 14);
        chk_cell("num45_u", 2, 15);
        do_num("num1023_busy", 2, 13, 1023);
        chk_cell("num1023_h", 2, 13);
        chk_cell("num1023_t", 2, 14);
        chk_cell("num1023_u", 2, 15);
        do_num("num7_busy", 1, 15, 7);
        chk_cell("num7_h", 1, 15);
        chk_cell("num7_t", 1, 16);
        chk_cell("num7_row2_x0", 2, 0);
        do_num("num100_busy", 3, 0, 100);
        do_num("num905_busy", 0, 5, 905);
        scan("num_scan");

        do_clr("clr_prio_len", 1'b1);
        scan("clr_prio_scan");

        // Reset in the middle of a number operation restarts the clear.
        do_wr(3, 3, 65);
        bus.num_req = 1'b1;
        bus.num_yx  = {Y_W'(3), X_W'(2)};
        bus.num_val = 10'd999;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 1);
        wait_busy(n);
        check("midrst_clear_len", n, 68);
        model_clear();
        scan("midrst_scan");

        for (int it = 0; it < 40; it++) begin
            int op, y, x;
            op = $urandom_range(0, 9);
            y  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 31) : $urandom_range(0, 3);
            x  = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            if (op <= 4)      do_wr(y, x, $urandom_range(1, 127));
            else if (op <= 7) do_num("rnd_num_busy", y, x, $urandom_range(0, 1023));
            else if (op == 8) do_clr("rnd_clr_len", 1'($urandom_range(0, 1)));
            else              scan("rnd_scan");
            for (int k = 0; k < 3; k++)
                chk_cell("rnd_rd", $urandom_range(0, 5), $urandom_range(0, 20));
        end
        scan("final_scan");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
